// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queued UART transmitter, LSB-first frames paced by baud_tick.
// A circular FIFO feeds a five-state serialiser with optional parity.
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        baud_tick,
    input  logic                        wr_valid,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic PAR_ODD = (PARITY_MODE == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                not_empty;
    logic [DATA_BITS-1:0] head;

    assign wr_ready   = (count_q != FULL);
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign tx_done    = done_q;
    assign tx_busy    = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        mem_d      = mem_q;
        pop        = 1'b0;
        push       = wr_valid && wr_ready;
        not_empty  = (count_q != '0);
        head       = mem_q[rd_ptr_q];

        unique case (state_q)
            S_IDLE: begin
                if (baud_tick && not_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q != LAST_STOP) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Chain straight into the next frame when data waits.
                        if (not_empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d  = head;
            par_d    = (^head) ^ PAR_ODD;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Line level follows the state being entered on this edge.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_cnt_d];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three configurations (8N1, 7O2, 8E1) share one clock;
// a serial-line monitor decodes frames and checks them against a queue.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       tick = 1'b0;
    logic [2:0] en  = 3'b000;
    logic [2:0] rst = 3'b000;
    logic [2:0] bt;
    assign bt = {3{tick}} & en;

    logic       wv0 = 1'b0, wv1 = 1'b0, wv2 = 1'b0;
    logic [7:0] wd0 = '0;
    logic [6:0] wd1 = '0;
    logic [7:0] wd2 = '0;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] cnt0, cnt1, cnt2;

    uart_tx_fifo u0 (
        .clk(clk), .reset(rst[0]), .baud_tick(bt[0]),
        .wr_valid(wv0), .wr_data(wd0), .wr_ready(rdy0),
        .tx(tx0), .tx_busy(busy0), .tx_done(done0), .fifo_count(cnt0)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(rst[1]), .baud_tick(bt[1]),
        .wr_valid(wv1), .wr_data(wd1), .wr_ready(rdy1),
        .tx(tx1), .tx_busy(busy1), .tx_done(done1), .fifo_count(cnt1)
    );

    uart_tx_fifo #(.PARITY_MODE(1)) u2 (
        .clk(clk), .reset(rst[2]), .baud_tick(bt[2]),
        .wr_valid(wv2), .wr_data(wd2), .wr_ready(rdy2),
        .tx(tx2), .tx_busy(busy2), .tx_done(done2), .fifo_count(cnt2)
    );

    // One-cycle baud strobe every 16 clocks.
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (c == 15);
            c = (c + 1) % 16;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int nb(input int id);
        return (id == 1) ? 7 : 8;
    endfunction
    function automatic int np(input int id);
        return (id == 1) ? 1 : ((id == 2) ? 1 : 0);
    endfunction
    function automatic int ns(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    // Expected entry: {back_to_back, parity, data[8:0]}
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    task automatic exp_push(input int id, input logic [10:0] e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask
    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction
    function automatic logic [10:0] qpop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    logic        inf   [3] = '{1'b0, 1'b0, 1'b0};
    logic        pend  [3] = '{1'b0, 1'b0, 1'b0};
    int          pos   [3] = '{0, 0, 0};
    logic [15:0] fb    [3] = '{16'h0, 16'h0, 16'h0};
    int          gap   [3] = '{0, 0, 0};
    int          lgap  [3] = '{0, 0, 0};
    int          frames[3] = '{0, 0, 0};
    int          dones [3] = '{0, 0, 0};
    int          busyc [3] = '{0, 0, 0};

    task automatic mon_reset(input int id);
        inf[id]  = 1'b0;
        pend[id] = 1'b0;
        pos[id]  = 0;
        gap[id]  = 0;
    endtask

    // Called on the sampling edge of each baud tick: b is the bit now ending.
    task automatic mon_tick(input int id, input logic b, input logic busy);
        logic [10:0] e;
        logic [8:0]  d;
        logic        stp;
        int          len;
        chk($sformatf("busy%0d", id), int'(busy), int'(inf[id] || !b));
        if (!inf[id]) begin
            if (!b) begin
                inf[id]  = 1'b1;
                pos[id]  = 0;
                fb[id]   = '0;
                lgap[id] = gap[id];
                gap[id]  = 0;
            end else begin
                gap[id]++;
            end
        end else begin
            fb[id][pos[id]] = b;
            pos[id]++;
            len = nb(id) + np(id) + ns(id);
            if (pos[id] == len) begin
                inf[id]  = 1'b0;
                pend[id] = 1'b1;
                frames[id]++;
                chk($sformatf("frame_expected%0d", id), int'(qsize(id) > 0), 1);
                if (qsize(id) > 0) begin
                    e = qpop(id);
                    d = '0;
                    for (int k = 0; k < nb(id); k++) d[k] = fb[id][k];
                    chk($sformatf("data%0d", id), int'(d), int'(e[8:0]));
                    if (np(id) != 0)
                        chk($sformatf("parity%0d", id), int'(fb[id][nb(id)]), int'(e[9]));
                    stp = 1'b1;
                    for (int k = nb(id) + np(id); k < len; k++) stp &= fb[id][k];
                    chk($sformatf("stop%0d", id), int'(stp), 1);
                    if (e[10]) chk($sformatf("gap%0d", id), lgap[id], 0);
                end
            end
        end
    endtask

    task automatic done_step(input int id, input logic done);
        if (pend[id]) begin
            chk($sformatf("tx_done%0d", id), int'(done), 1);
            pend[id] = 1'b0;
        end else if (done) begin
            chk($sformatf("tx_done_spurious%0d", id), int'(done), 0);
        end
        if (done) dones[id]++;
    endtask

    always @(negedge clk) begin
        done_step(0, done0);
        if (bt[0]) mon_tick(0, tx0, busy0);
        if (busy0) busyc[0]++;
    end
    always @(negedge clk) begin
        done_step(1, done1);
        if (bt[1]) mon_tick(1, tx1, busy1);
        if (busy1) busyc[1]++;
    end
    always @(negedge clk) begin
        done_step(2, done2);
        if (bt[2]) mon_tick(2, tx2, busy2);
        if (busy2) busyc[2]++;
    end

    // Stimulus tasks start and end at posedge+2.
    task automatic wr(input int id, input logic [7:0] d);
        case (id)
            0: begin wv0 = 1'b1; wd0 = d; end
            1: begin wv1 = 1'b1; wd1 = d[6:0]; end
            default: begin wv2 = 1'b1; wd2 = d; end
        endcase
        @(posedge clk);
        #2;
        wv0 = 1'b0;
        wv1 = 1'b0;
        wv2 = 1'b0;
    endtask

    task automatic wait_tick(input int id);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!bt[id] && n < 100);
        if (!bt[id]) chk("tick_timeout", int'(bt[id]), 1);
    endtask

    task automatic wait_frames(input int id, input int target);
        int n;
        n = 0;
        while (frames[id] < target && n < 6000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk($sformatf("frames%0d", id), frames[id], target);
    endtask

    initial begin
        #1;
        rst = 3'b111;
        #1;
        chk("rst_tx0", int'(tx0), 1);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_rdy0", int'(rdy0), 1);
        chk("rst_tx1", int'(tx1), 1);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_rdy1", int'(rdy1), 1);
        chk("rst_tx2", int'(tx2), 1);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_done2", int'(done2), 0);
        chk("rst_cnt2", int'(cnt2), 0);
        chk("rst_rdy2", int'(rdy2), 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 3'b000;

        // 8N1, 0xA5 while idle
        en[0] = 1'b1;
        exp_push(0, {1'b0, 1'b0, 9'h0A5});
        wr(0, 8'hA5);
        chk("a5_cnt_queued", int'(cnt0), 1);
        busyc[0] = 0;
        wait_tick(0);
        chk("a5_tx_pre", int'(tx0), 1);
        @(posedge clk);
        #1;
        chk("a5_tx_start", int'(tx0), 0);
        chk("a5_cnt_launch", int'(cnt0), 0);
        chk("a5_busy", int'(busy0), 1);
        #1;
        wait_frames(0, 1);
        chk("a5_busy_cycles", busyc[0], 160);
        chk("a5_dones", dones[0], 1);

        // 7O2, 0x41 -> odd parity bit 1
        en[1] = 1'b1;
        busyc[1] = 0;
        exp_push(1, {1'b0, 1'b1, 9'h041});
        wr(1, 8'h41);
        wait_frames(1, 1);
        chk("o2_busy_cycles", busyc[1], 176);

        // 8E1, 0x03 -> parity 0, 0x07 -> parity 1, sent back-to-back
        exp_push(2, {1'b0, 1'b0, 9'h003});
        exp_push(2, {1'b1, 1'b1, 9'h007});
        wr(2, 8'h03);
        wr(2, 8'h07);
        chk("e1_cnt", int'(cnt2), 2);
        en[2] = 1'b1;
        wait_frames(2, 2);

        // FIFO full with transmitter stalled
        en[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wv0 = 1'b1;
            wd0 = 8'h11 + 8'(k);
            chk($sformatf("full_rdy%0d", k), int'(rdy0), (k < 4) ? 1 : 0);
            @(posedge clk);
            #2;
        end
        wv0 = 1'b0;
        chk("full_cnt", int'(cnt0), 4);
        chk("full_rdy_after", int'(rdy0), 0);
        exp_push(0, {1'b0, 1'b0, 9'h011});
        exp_push(0, {1'b1, 1'b0, 9'h012});
        exp_push(0, {1'b1, 1'b0, 9'h013});
        exp_push(0, {1'b1, 1'b0, 9'h014});
        en[0] = 1'b1;
        wait_frames(0, 5);
        chk("full_dones", dones[0], 5);
        chk("full_cnt_end", int'(cnt0), 0);

        // Push and pop on the same edge at the end of a stop bit
        en[0] = 1'b0;
        exp_push(0, {1'b0, 1'b0, 9'h010});
        exp_push(0, {1'b1, 1'b0, 9'h020});
        exp_push(0, {1'b1, 1'b0, 9'h022});
        wr(0, 8'h10);
        wr(0, 8'h20);
        chk("sim_cnt2", int'(cnt0), 2);
        en[0] = 1'b1;
        wait_tick(0);
        repeat (10) wait_tick(0);
        wv0 = 1'b1;
        wd0 = 8'h22;
        chk("sim_cnt_before", int'(cnt0), 1);
        @(posedge clk);
        #1;
        chk("sim_cnt_after", int'(cnt0), 1);
        chk("sim_tx_start", int'(tx0), 0);
        chk("sim_busy", int'(busy0), 1);
        #1;
        wv0 = 1'b0;
        wait_frames(0, 8);

        // Reset in DATA bit 3 of 0x5A with two words behind it
        en[0] = 1'b0;
        wr(0, 8'h5A);
        wr(0, 8'h33);
        wr(0, 8'h44);
        en[0] = 1'b1;
        wait_tick(0);
        repeat (4) wait_tick(0);
        @(posedge clk);
        #3;
        chk("rd_busy_pre", int'(busy0), 1);
        chk("rd_cnt_pre", int'(cnt0), 2);
        rst[0] = 1'b1;
        mon_reset(0);
        #1;
        chk("rd_tx", int'(tx0), 1);
        chk("rd_busy", int'(busy0), 0);
        chk("rd_cnt", int'(cnt0), 0);
        chk("rd_rdy", int'(rdy0), 1);
        chk("rd_done", int'(done0), 0);
        @(posedge clk);
        #2;
        rst[0] = 1'b0;
        repeat (400) @(posedge clk);
        #2;
        chk("rd_frames", frames[0], 8);
        chk("rd_dones", dones[0], 8);
        chk("rd_cnt_end", int'(cnt0), 0);
        chk("rd_tx_end", int'(tx0), 1);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("queue_empty%0d", i), qsize(i), 0);
            chk($sformatf("done_vs_frames%0d", i), dones[i], frames[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO. Data width, parity and stop-bit count are configurable. Words are pushed through a valid/ready interface, and frames are serialised LSB-first, aligned to an external one-cycle baud_tick strobe. It replaces the single-word transmitter in the CPU peripheral bus path, so software can queue bursts without polling per byte.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
baud_tick  in  1  one-clk pulse per bit period
wr_valid  in  1  write request
wr_data  in  DATA_BITS  word to queue
wr_ready  out  1  FIFO not full; a write occurs when wr_valid && wr_ready
tx  out  1  serial line, idle high, registered
tx_busy  out  1  high while a frame is in progress
tx_done  out  1  one-cycle pulse when a frame's last stop bit completes
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high) forces, without waiting for a clock edge:
  - tx = 1, tx_busy = 0, tx_done = 0
  - fifo_count = 0, wr_ready = 1
  - state = IDLE; FIFO pointers, shift register and bit counter cleared
- Reset mid-frame aborts the frame immediately. Queued words are discarded. tx returns high asynchronously.
- FIFO behaviour:
  - Circular buffer with wrap-around pointers.
  - wr_ready = (fifo_count != FIFO_DEPTH).
  - Writes while full are ignored; contents and count are unchanged.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A pop requires fifo_count != 0 as registered, so a word written into an empty FIFO is not popped in the same cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, tx_busy = 0.
  - On a baud_tick with the FIFO non-empty: pop the head word into the shift register, compute the parity bit, go to START.
  - Without a baud_tick, stay in IDLE even if data is waiting. This guarantees every bit lasts a full baud period.
- START:
  - tx = 0.
  - On baud_tick: bit counter = 0, go to DATA.
- DATA:
  - tx = shift register bit[counter], LSB first.
  - On baud_tick: if counter == DATA_BITS-1, go to PARITY (PARITY_MODE != 0) or STOP (PARITY_MODE == 0); otherwise counter + 1.
- PARITY:
  - tx = parity bit.
  - Even mode: parity = XOR of all data bits. Odd mode: parity = the inverse of that XOR.
  - On baud_tick: stop counter = 0, go to STOP.
- STOP:
  - tx = 1.
  - On a baud_tick with stop counter < STOP_BITS-1: increment the stop counter.
  - On the baud_tick ending the final stop bit: tx_done = 1 on the next cycle, for exactly one cycle.
    - If the FIFO is non-empty at that same tick, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- tx and tx_done are registered and update on the same edge as the state change.
- tx_busy is 1 in every state except IDLE.
- Frame length: 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS baud periods.
- Latency: tx falls on the clock edge of the first baud_tick seen with the FIFO non-empty in IDLE.
- baud_tick is sampled only in the current state. Ticks arriving while IDLE with an empty FIFO have no effect.
- PARITY_MODE = 3 and out-of-range parameter values are illegal. The block must flag them with an elaboration-time error.

Test Plan:
- Defaults (8N1). Write 0xA5 while idle, baud_tick every 16 clks. tx sequence: 0, 1,0,1,0,0,1,0,1, 1. tx_done pulses once; tx_busy spans 10 bit periods; fifo_count goes 1 → 0 at frame launch.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2. Send 0x41. tx sequence: 0, 1,0,0,0,0,0,1, 1 (odd parity), 1,1. Frame is 11 bit periods.
- PARITY_MODE=1. Send 0x03. Parity bit = 0. Send 0x07. Parity bit = 1.
- FIFO_DEPTH=4, transmitter stalled (no baud_tick). Write 5 words 0x11–0x15 back-to-back: wr_ready drops after the 4th, fifo_count = 4, 0x15 is dropped. Enable baud_tick: frames 0x11..0x14 go out back-to-back with no idle bit between them, and tx_done pulses 4 times.
- Assert reset for 1 clk during DATA bit 3 of 0x5A, with 2 words queued. tx = 1 immediately, fifo_count = 0, state = IDLE. No further frames and no tx_done.
- Simultaneous write and pop. Set fifo_count = 1, write 0x22 on the baud_tick cycle that ends a STOP. The next frame starts and fifo_count stays 1.
